bnn_row_array_v2: RTL and testbench

//  Parametrised binary-conv row engine: broadcasts XNOR-popcount activations to O_CH output-channel rows,

---
 rtl/bnn_pkg.sv | 31 +++
 rtl/bnn_row_array_v2_if.sv | 24 ++
 rtl/bnn_xnor_pe.sv | 42 ++++
 rtl/bnn_row_array_v2.sv | 195 +++++++++++++++++++
 tb/tb_bnn_row_array_v2.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared types and arithmetic helpers for the binary-conv row engine.
package bnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        POP
    } state_t;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Signed width able to hold every contribution in [-act_w, +act_w].
    function automatic int contrib_width(input int act_w);
        return $clog2(act_w + 1) + 1;
    endfunction

    // XNOR-popcount mapped onto the +/-1 domain: matches minus mismatches.
    function automatic int contrib_value(input int pc, input int act_w);
        return 2 * pc - act_w;
    endfunction

endpackage

// File: rtl/bnn_row_array_v2_if.sv
// Pad-side bus of the row engine: weight/activation input, controls and pop output.
interface bnn_row_array_v2_if #(
    parameter int ACT_W   = 9,
    parameter int ROW_LEN = 10
);
    logic [ACT_W-1:0]   data_in;
    logic               load_weight_in;
    logic               in_valid_in;
    logic               clear_in;
    logic               pop_in;
    logic [ROW_LEN-1:0] sum_out;
    logic               sum_valid_out;
    logic               busy_out;

    modport master (
        output data_in, load_weight_in, in_valid_in, clear_in, pop_in,
        input  sum_out, sum_valid_out, busy_out
    );

    modport slave (
        input  data_in, load_weight_in, in_valid_in, clear_in, pop_in,
        output sum_out, sum_valid_out, busy_out
    );
endinterface

// File: rtl/bnn_xnor_pe.sv
// Combinational XNOR-popcount processing element: psum_out = psum_in + contrib(act, weight).
// Optional clamping instead of wraparound when BNN_PSUM_SAT_EN is defined.
module bnn_xnor_pe
    import bnn_pkg::*;
#(
    parameter int ACT_W  = 9,
    parameter int PSUM_W = 14
) (
    input  logic        [ACT_W-1:0]  act,
    input  logic        [ACT_W-1:0]  weight,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic signed [PSUM_W-1:0] psum_out
);
    localparam int CW = contrib_width(ACT_W);

    logic [31:0]          match_ext;
    logic signed [CW-1:0] contrib;

    always_comb begin
        match_ext             = '0;
        match_ext[ACT_W-1:0]  = ~(act ^ weight);
        contrib               = CW'(contrib_value(popcount(match_ext), ACT_W));
    end

`ifdef BNN_PSUM_SAT_EN
    logic signed [PSUM_W:0] wide_sum;

    assign wide_sum = (PSUM_W+1)'(psum_in) + (PSUM_W+1)'(contrib);

    // Disagreeing top two bits of the extended sum flag an overflow.
    always_comb begin
        psum_out = wide_sum[PSUM_W-1:0];
        if (wide_sum[PSUM_W] != wide_sum[PSUM_W-1]) begin
            psum_out = wide_sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                        : {1'b0, {(PSUM_W-1){1'b1}}};
        end
    end
`else
    assign psum_out = psum_in + PSUM_W'(contrib);
`endif

endmodule

// File: rtl/bnn_row_array_v2.sv
// Binary-conv row engine: skewed activation broadcast to O_CH XNOR PEs, rotating psum rings,
// one-channel-per-cycle sign pop. Saturating accumulate selected by BNN_PSUM_SAT_EN.
module bnn_row_array_v2
    import bnn_pkg::*;
#(
    parameter int ACT_W   = 9,
    parameter int O_CH    = 64,
    parameter int ROW_LEN = 10,
    parameter int PSUM_W  = 14,
    parameter int CNT_W   = $clog2(O_CH)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    bnn_row_array_v2_if.slave bus
);
    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         wcnt_reg, wcnt_next;
    logic [CNT_W-1:0]         pcnt_reg, pcnt_next;
    logic [CNT_W-1:0]         dcnt_reg, dcnt_next;
    logic                     wdone_reg, wdone_next;
    logic                     act_accept;
    logic                     weight_we;
    logic [ACT_W-1:0]         act_gated;

    logic [ACT_W-1:0]         weight_reg   [O_CH];
    logic [ACT_W-1:0]         ch_act       [O_CH];
    logic                     ch_vld       [O_CH];
    logic [ACT_W-1:0]         skew_act_reg [1:O_CH-1];
    logic                     skew_vld_reg [1:O_CH-1];
    logic signed [PSUM_W-1:0] ring_reg     [O_CH][ROW_LEN];
    logic signed [PSUM_W-1:0] pe_sum       [O_CH];

    logic [ROW_LEN-1:0]       pop_bits;
    logic [ROW_LEN-1:0]       sum_reg;
    logic                     sum_valid_reg;

    // Activations enter the chain in IDLE too, so a single-cycle valid pulse is never lost.
    always_comb begin
        act_accept = bus.in_valid_in && !bus.clear_in &&
                     (state_reg == COMPUTE || state_reg == DRAIN ||
                      (state_reg == IDLE && !bus.load_weight_in));
        act_gated  = act_accept ? bus.data_in : '0;
        weight_we  = bus.load_weight_in && !bus.clear_in && !wdone_reg &&
                     (state_reg == IDLE || state_reg == LOAD);
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        wdone_next = wdone_reg;
        pcnt_next  = pcnt_reg;
        dcnt_next  = dcnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.load_weight_in)   state_next = LOAD;
                else if (bus.in_valid_in) state_next = COMPUTE;
                else if (bus.pop_in)      state_next = POP;
            end
            LOAD: begin
                if (!bus.load_weight_in) begin
                    state_next = IDLE;
                    wcnt_next  = '0;
                    wdone_next = 1'b0;
                end
            end
            COMPUTE: begin
                if (!bus.in_valid_in) begin
                    state_next = DRAIN;
                    dcnt_next  = '0;
                end
            end
            DRAIN: begin
                if (bus.in_valid_in)                     state_next = COMPUTE;
                else if (dcnt_reg == CNT_W'(O_CH - 2))   state_next = IDLE;
                else                                     dcnt_next  = dcnt_reg + 1'b1;
            end
            POP: begin
                if (!bus.pop_in) begin
                    state_next = IDLE;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = (pcnt_reg == CNT_W'(O_CH - 1)) ? '0 : pcnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The last slot is written once; further words are dropped until LOAD ends.
        if (weight_we) begin
            if (wcnt_reg == CNT_W'(O_CH - 1)) wdone_next = 1'b1;
            else                              wcnt_next  = wcnt_reg + 1'b1;
        end

        if (bus.clear_in) begin
            state_next = IDLE;
            wcnt_next  = '0;
            wdone_next = 1'b0;
            pcnt_next  = '0;
            dcnt_next  = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
            wdone_reg <= 1'b0;
            pcnt_reg  <= '0;
            dcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            wdone_reg <= wdone_next;
            pcnt_reg  <= pcnt_next;
            dcnt_reg  <= dcnt_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < O_CH; i++) weight_reg[i] <= '0;
        end else if (weight_we) begin
            weight_reg[wcnt_reg] <= bus.data_in;
        end
    end

    assign ch_act[0] = act_gated;
    assign ch_vld[0] = act_accept;

    genvar gi;
    generate
        for (gi = 1; gi < O_CH; gi++) begin : g_skew
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    skew_act_reg[gi] <= '0;
                    skew_vld_reg[gi] <= 1'b0;
                end else if (bus.clear_in) begin
                    skew_act_reg[gi] <= '0;
                    skew_vld_reg[gi] <= 1'b0;
                end else begin
                    skew_act_reg[gi] <= ch_act[gi-1];
                    skew_vld_reg[gi] <= ch_vld[gi-1];
                end
            end
            assign ch_act[gi] = skew_act_reg[gi];
            assign ch_vld[gi] = skew_vld_reg[gi];
        end

        for (gi = 0; gi < O_CH; gi++) begin : g_ch
            bnn_xnor_pe #(
                .ACT_W  (ACT_W),
                .PSUM_W (PSUM_W)
            ) u_pe (
                .act      (ch_act[gi]),
                .weight   (weight_reg[gi]),
                .psum_in  (ring_reg[gi][ROW_LEN-1]),
                .psum_out (pe_sum[gi])
            );

            // Ring rotates one slot per accepted activation; the tail re-enters at the head.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    for (int k = 0; k < ROW_LEN; k++) ring_reg[gi][k] <= '0;
                end else if (bus.clear_in) begin
                    for (int k = 0; k < ROW_LEN; k++) ring_reg[gi][k] <= '0;
                end else if (ch_vld[gi]) begin
                    ring_reg[gi][0] <= pe_sum[gi];
                    for (int k = 1; k < ROW_LEN; k++) ring_reg[gi][k] <= ring_reg[gi][k-1];
                end
            end
        end
    endgenerate

    always_comb begin
        pop_bits = '0;
        for (int k = 0; k < ROW_LEN; k++) begin
            pop_bits[ROW_LEN-1-k] = ring_reg[pcnt_reg][k][PSUM_W-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            sum_valid_reg <= (state_reg == POP);
            if (state_reg == POP) sum_reg <= pop_bits;
        end
    end

    assign bus.sum_out       = sum_reg;
    assign bus.sum_valid_out = sum_valid_reg;
    assign bus.busy_out      = (state_reg == LOAD) || (state_reg == COMPUTE) || (state_reg == DRAIN);

endmodule

// File: tb/tb_bnn_row_array_v2.sv
// Bench for bnn_row_array_v2: a full-size engine plus a tiny 5-bit-psum engine for overflow,
// checked against a slot-sum model of the rotating rings.
module tb_bnn_row_array_v2;
    localparam int O_CH   = 64;
    localparam int B_OCH  = 4;

`ifdef BNN_PSUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bnn_row_array_v2_if #(.ACT_W(9), .ROW_LEN(10)) bus_a ();
    bnn_row_array_v2_if #(.ACT_W(9), .ROW_LEN(2))  bus_b ();

    bnn_row_array_v2 #(.ACT_W(9), .O_CH(64), .ROW_LEN(10), .PSUM_W(14)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_a)
    );

    bnn_row_array_v2 #(.ACT_W(9), .O_CH(4), .ROW_LEN(2), .PSUM_W(5)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_b)
    );

    int checks = 0;
    int passed = 0;

    logic [8:0] mw_a [64];
    logic [8:0] mw_b [4];
    logic [8:0] acts_a [$];
    logic [8:0] acts_b [$];
    logic [9:0] exp_a [$];
    logic [9:0] exp_b [$];
    int         lit_a [$];
    int         lit_b [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    endtask

    // Slot j of a channel accumulates every activation i with i % ROW_LEN == j; after n
    // accumulations ring position k holds slot (n-1-k) mod ROW_LEN.
    function automatic logic [9:0] model_word(input int sel, input int c);
        int r, pw, n, v, pc, idx;
        int slot [10];
        logic [8:0] w, a;
        logic [9:0] word;
        r  = (sel == 0) ? 10 : 2;
        pw = (sel == 0) ? 14 : 5;
        n  = (sel == 0) ? acts_a.size() : acts_b.size();
        w  = (sel == 0) ? mw_a[c] : mw_b[c];
        for (int j = 0; j < 10; j++) slot[j] = 0;
        for (int i = 0; i < n; i++) begin
            a  = (sel == 0) ? acts_a[i] : acts_b[i];
            pc = $countones(~(a ^ w));
            v  = slot[i % r] + 2 * pc - 9;
            if (SAT) begin
                if (v > (1 << (pw - 1)) - 1) v = (1 << (pw - 1)) - 1;
                if (v < -(1 << (pw - 1)))    v = -(1 << (pw - 1));
            end else begin
                v = v & ((1 << pw) - 1);
                if (v >= (1 << (pw - 1))) v = v - (1 << pw);
            end
            slot[i % r] = v;
        end
        word = '0;
        for (int k = 0; k < r; k++) begin
            idx = (((n - 1 - k) % r) + r) % r;
            word[r-1-k] = (slot[idx] < 0);
        end
        return word;
    endfunction

    task automatic drive(input int sel, input logic [8:0] d, input logic ld, input logic vl,
                         input logic cl, input logic pp);
        if (sel == 0) begin
            bus_a.data_in = d; bus_a.load_weight_in = ld; bus_a.in_valid_in = vl;
            bus_a.clear_in = cl; bus_a.pop_in = pp;
        end else begin
            bus_b.data_in = d; bus_b.load_weight_in = ld; bus_b.in_valid_in = vl;
            bus_b.clear_in = cl; bus_b.pop_in = pp;
        end
    endtask

    task automatic load_weights(input int sel, input int extra);
        int och;
        och = (sel == 0) ? O_CH : B_OCH;
        for (int c = 0; c < och; c++) begin
            drive(sel, (sel == 0) ? mw_a[c] : mw_b[c], 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        for (int e = 0; e < extra; e++) begin
            drive(sel, 9'(9'h0AA + e), 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(sel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_pulse(input int sel);
        drive(sel, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(sel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (sel == 0) acts_a.delete(); else acts_b.delete();
        @(negedge clk);
    endtask

    task automatic send_act(input int sel, input logic [8:0] a);
        drive(sel, a, 1'b0, 1'b1, 1'b0, 1'b0);
        if (sel == 0) acts_a.push_back(a); else acts_b.push_back(a);
        @(negedge clk);
    endtask

    task automatic finish_acts(input int sel);
        logic b;
        drive(sel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        b = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            b = (sel == 0) ? bus_a.busy_out : bus_b.busy_out;
            if (!b) break;
        end
        chk("drain_done", b, 1'b0);
    endtask

    task automatic do_pop(input int sel, input int n, input int lit);
        int och;
        logic [9:0] last;
        och  = (sel == 0) ? O_CH : B_OCH;
        last = '0;
        for (int i = 0; i < n; i++) begin
            last = model_word(sel, i % och);
            if (sel == 0) begin exp_a.push_back(last); lit_a.push_back(lit); end
            else          begin exp_b.push_back(last); lit_b.push_back(lit); end
            drive(sel, '0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(sel, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (sel == 0) begin
            chk("pop_all_seen_a", exp_a.size(), 0);
            chk("pop_hold_a", bus_a.sum_out, last);
        end else begin
            chk("pop_all_seen_b", exp_b.size(), 0);
            chk("pop_hold_b", bus_b.sum_out, last);
        end
    endtask

    // Every popped word is checked against the model and, where given, a literal.
    always @(negedge clk) begin : cmp
        logic [9:0] e;
        int l;
        if (!rst) begin
            if (bus_a.sum_valid_out) begin
                if (exp_a.size() == 0) chk("a_unexpected_valid", bus_a.sum_valid_out, 1'b0);
                else begin
                    e = exp_a.pop_front(); l = lit_a.pop_front();
                    chk("a_pop_model", bus_a.sum_out, e);
                    if (l >= 0) chk("a_pop_literal", bus_a.sum_out, 64'(l));
                end
            end
            if (bus_b.sum_valid_out) begin
                if (exp_b.size() == 0) chk("b_unexpected_valid", bus_b.sum_valid_out, 1'b0);
                else begin
                    e = exp_b.pop_front(); l = lit_b.pop_front();
                    chk("b_pop_model", {8'b0, bus_b.sum_out}, e);
                    if (l >= 0) chk("b_pop_literal", {8'b0, bus_b.sum_out}, 64'(l));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int h;
        logic [8:0] pat [13];
        pat = '{9'h1FF, 9'h000, 9'h155, 9'h0AA, 9'h1F0, 9'h00F, 9'h123,
                9'h1C7, 9'h038, 9'h101, 9'h0F3, 9'h16C, 9'h07E};
        drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sum_out", bus_a.sum_out, 0);
        chk("reset_sum_valid", bus_a.sum_valid_out, 0);
        chk("reset_busy", bus_a.busy_out, 0);
        chk("reset_busy_b", bus_b.busy_out, 0);

        // Reset in the middle of a weight load
        for (int i = 0; i < 5; i++) begin
            drive(0, 9'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        chk("t1_busy_in_load", bus_a.busy_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_busy_at_reset", bus_a.busy_out, 0);
        chk("t1_sum_out_at_reset", bus_a.sum_out, 0);
        chk("t1_valid_at_reset", bus_a.sum_valid_out, 0);
        h = dut.weight_reg[0];
        chk("t1_weight_lost", h, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 64; c++) mw_a[c] = 9'((c * 73 + 11) % 512);
        load_weights(0, 2);
        h = dut.weight_reg[63];
        chk("t1_weight63_last_word", h, int'(mw_a[63]));
        h = dut.weight_reg[0];
        chk("t1_weight0", h, int'(mw_a[0]));

        // Mixed activations, more than one ring revolution
        for (int i = 0; i < 13; i++) send_act(0, pat[i]);
        finish_acts(0);
        do_pop(0, 64, -1);

        // All-ones weights and activations: every entry +9
        clear_pulse(0);
        for (int c = 0; c < 64; c++) mw_a[c] = 9'h1FF;
        load_weights(0, 0);
        for (int i = 0; i < 10; i++) send_act(0, 9'h1FF);
        finish_acts(0);
        do_pop(0, 64, 0);

        // Zero weights: every entry -9, pop counter wraps past the last channel
        clear_pulse(0);
        for (int c = 0; c < 64; c++) mw_a[c] = 9'h000;
        load_weights(0, 0);
        for (int i = 0; i < 10; i++) send_act(0, 9'h1FF);
        finish_acts(0);
        do_pop(0, 66, 10'h3FF);

        // Skew timing of a single activation; pop requests during drain are ignored
        clear_pulse(0);
        drive(0, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0);
        acts_a.push_back(9'h1FF);
        @(negedge clk);
        drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            h = dut.ring_reg[k-1][0];
            chk("t4_head_updated", h, -9);
            if (k < 64) begin
                h = dut.ring_reg[k][0];
                chk("t4_head_not_yet", h, 0);
            end
            chk("t4_busy", bus_a.busy_out, 1);
            drive(0, '0, 1'b0, 1'b0, 1'b0, (k >= 10 && k < 20));
            @(negedge clk);
        end
        chk("t4_idle_after_drain", bus_a.busy_out, 0);
        do_pop(0, 64, 10'h200);

        // Clear in the middle of COMPUTE
        clear_pulse(0);
        for (int c = 0; c < 64; c++) mw_a[c] = 9'((c * 29 + 300) % 512);
        load_weights(0, 0);
        for (int i = 0; i < 4; i++) send_act(0, pat[i + 2]);
        drive(0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        acts_a.delete();
        chk("t6_idle_after_clear", bus_a.busy_out, 0);
        h = dut.ring_reg[0][0];
        chk("t6_ring0_cleared", h, 0);
        h = dut.ring_reg[3][0];
        chk("t6_ring3_cleared", h, 0);
        h = dut.weight_reg[5];
        chk("t6_weights_kept", h, int'(mw_a[5]));
        @(negedge clk);
        do_pop(0, 64, 0);
        for (int i = 0; i < 3; i++) send_act(0, pat[i + 7]);
        finish_acts(0);
        do_pop(0, 64, -1);

        // Narrow psum: two +9 accumulations per entry overflow 5 bits
        for (int c = 0; c < 4; c++) mw_b[c] = 9'h1FF;
        load_weights(1, 0);
        for (int i = 0; i < 4; i++) send_act(1, 9'h1FF);
        finish_acts(1);
        do_pop(1, 4, SAT ? 0 : 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
